// File: rtl/pkt_buf_mem_if.sv
// rtl/pkt_buf_mem_if.sv - bundled load, executor, dump and status signals of pkt_buf_mem
//
// Purpose: groups every non-clock/reset signal of the packet buffer.
// Signal groups:
//   load stream   : in_valid_i, in_data_i, in_last_i -> in_ready_o
//   status        : pkt_ready_o, pkt_len_o
//   executor port : mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i -> mem_data_o
//   dump stream   : dump_start_i, out_ready_i -> out_valid_o, out_data_o, out_last_o
// Modports: slave = buffer side, master = driver side.
interface pkt_buf_mem_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid_i;
  logic [7:0]        in_data_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic              pkt_ready_o;
  logic [ADDR_W:0]   pkt_len_o;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_width_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              dump_start_i;
  logic              out_valid_o;
  logic [7:0]        out_data_o;
  logic              out_last_o;
  logic              out_ready_i;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i,
    output in_ready_o, pkt_ready_o, pkt_len_o,
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
    output mem_data_o,
    input  dump_start_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i,
    input  in_ready_o, pkt_ready_o, pkt_len_o,
    output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
    input  mem_data_o,
    output dump_start_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/pkt_buf_mem.sv
// rtl/pkt_buf_mem.sv - byte-addressed packet buffer with load, execute and dump phases
//
// Purpose: holds one packet at a time. Bytes arrive on the load stream, the
// executor reads/writes them big-endian while the packet is held, then the
// packet is streamed out on the dump port.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (buffer contents are kept)
//   bus  - pkt_buf_mem_if.slave: load stream, status, executor port, dump stream
module pkt_buf_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  pkt_buf_mem_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_rptr;
  logic [ADDR_W:0] r_pkt_len;
  logic            r_in_ready;
  logic [31:0]     r_mem_data;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_out_last;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_hold;
  logic [ADDR_W:0] w_load_idx;
  logic [ADDR_W:0] w_load_cnt;
  logic            w_load_we;
  logic            w_exec_we;
  logic [2:0]      w_width_eff;
  logic [32:0]     w_lane_addr [4];
  logic [3:0]      w_lane_ok;
  logic [1:0]      w_lane_pos [4];
  logic [31:0]     w_rdata;

  assign w_in_fire  = bus.in_valid_i & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready_i;
  assign w_hold     = (r_state == S_HOLD);

  // The first byte always lands at 0; later bytes use the pointer, which
  // saturates at DEPTH so overflow bytes are counted but never stored.
  assign w_load_idx = (r_state == S_IDLE) ? '0 : r_wptr;
  assign w_load_cnt = (r_state == S_IDLE) ? (ADDR_W + 1)'(1) :
                      ((r_wptr == LEN_MAX) ? r_wptr : r_wptr + 1'b1);
  assign w_load_we  = w_in_fire & ~rst & ~w_load_idx[ADDR_W];

  assign w_exec_we  = w_hold & bus.mem_ce_i & bus.mem_we_i & ~rst;

  always_comb begin
    if (bus.mem_width_i == 4'd0)      w_width_eff = 3'd0;
    else if (bus.mem_width_i > 4'd4)  w_width_eff = 3'd4;
    else                              w_width_eff = bus.mem_width_i[2:0];
  end

  // Lane k addresses byte addr+k. The 33-bit sum keeps a carry out of the
  // 32-bit address from wrapping back into the buffer. Lane k maps to byte
  // position w-1-k of the right-aligned word (big-endian).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lane_addr[k] = {1'b0, bus.mem_addr_i} + 33'(k);
      w_lane_ok[k]   = (3'(k) < w_width_eff) && (w_lane_addr[k] < 33'(DEPTH));
      w_lane_pos[k]  = 2'(w_width_eff - 3'(k) - 3'd1);
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane_ok[k]) begin
        w_rdata[{w_lane_pos[k], 3'b000} +: 8] = r_mem[w_lane_addr[k][ADDR_W-1:0]];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_in_fire) w_state_nxt = bus.in_last_i ? S_HOLD : S_LOAD;
      S_LOAD: if (w_in_fire && bus.in_last_i) w_state_nxt = S_HOLD;
      S_HOLD: if (bus.dump_start_i) w_state_nxt = S_DUMP;
      S_DUMP: if (w_out_fire && r_out_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage has no reset; load and executor writes never overlap because
  // they are enabled in disjoint states.
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      r_mem[w_load_idx[ADDR_W-1:0]] <= bus.in_data_i;
    end
    if (w_exec_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_ok[k]) begin
          r_mem[w_lane_addr[k][ADDR_W-1:0]] <= bus.mem_data_i[{w_lane_pos[k], 3'b000} +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_pkt_len   <= '0;
      r_in_ready  <= 1'b0;
      r_mem_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);

      if (w_in_fire) begin
        r_wptr <= w_load_cnt;
        if (bus.in_last_i) r_pkt_len <= w_load_cnt;
      end

      if (bus.mem_ce_i) begin
        if (!w_hold)              r_mem_data <= '0;
        else if (!bus.mem_we_i)   r_mem_data <= w_rdata;
      end

      // Output register refills when empty (entry cycle) or when the held
      // byte is taken; taking the last byte empties it and ends the dump.
      if (r_state == S_DUMP) begin
        if (w_out_fire && r_out_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else if (!r_out_valid || w_out_fire) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[r_rptr[ADDR_W-1:0]];
          r_out_last  <= ((r_rptr + 1'b1) == r_pkt_len);
          r_rptr      <= r_rptr + 1'b1;
        end
      end else begin
        r_rptr <= '0;
      end
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.pkt_ready_o = w_hold;
  assign bus.pkt_len_o   = r_pkt_len;
  assign bus.mem_data_o  = r_mem_data;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_last_o  = r_out_last;
endmodule

// File: tb/tb_pkt_buf_mem.sv
// tb/tb_pkt_buf_mem.sv - scoreboard bench for pkt_buf_mem
//
// Purpose: drives directed load/executor/dump vectors; expected read words and
// egress bytes are queued at issue time and checked by a separate monitor.
// Ports: none (top-level bench).
module tb_pkt_buf_mem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_buf_mem_if #(.ADDR_W(8)) bus ();

  pkt_buf_mem #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_t;

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  logic [31:0] rd_q[$];
  out_t        out_q[$];
  logic        rd_seen = 1'b0;
  logic [7:0]  pkt [0:511];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A read sampled at this edge presents its data for the following negedge.
  always @(posedge clk) rd_seen <= bus.mem_ce_i && !bus.mem_we_i && !rst;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got=%h want=no read pending", bus.mem_data_o);
      end else begin
        chk("rd_data", bus.mem_data_o, rd_q.pop_front());
      end
    end
    if (bus.out_valid_o) begin
      if (out_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_unexpected: got=%h want=no byte pending", bus.out_data_o);
      end else begin
        chk("out_data", {24'h0, bus.out_data_o}, {24'h0, out_q[0].data});
        chk("out_last", {31'h0, bus.out_last_o}, {31'h0, out_q[0].last});
        if (bus.out_ready_i) begin
          void'(out_q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic mem_op(input logic we, input logic [31:0] addr, input logic [3:0] w,
                        input logic [31:0] d, input logic [31:0] exp);
    bus.mem_ce_i    = 1'b1;
    bus.mem_we_i    = we;
    bus.mem_addr_i  = addr;
    bus.mem_width_i = w;
    bus.mem_data_i  = d;
    if (!we) rd_q.push_back(exp);
    step();
  endtask

  task automatic mem_idle();
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    step();
  endtask

  task automatic load(input int n, input logic end_last);
    int miss = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = pkt[i];
      bus.in_last_i  = end_last && (i == n - 1);
      if (bus.in_ready_o !== 1'b1) miss++;
      step();
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    chk("in_ready_during_load", miss, 0);
  endtask

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (bus.in_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk(name, {31'h0, bus.in_ready_o}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat [6] = '{1, 0, 0, 1, 1, 1};
    rst              = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.in_last_i    = 1'b0;
    bus.mem_ce_i     = 1'b0;
    bus.mem_we_i     = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_width_i  = '0;
    bus.mem_data_i   = '0;
    bus.dump_start_i = 1'b0;
    bus.out_ready_i  = 1'b0;
    step();
    step();
    chk("rst_in_ready",  {31'h0, bus.in_ready_o},  32'h0);
    chk("rst_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h0);
    chk("rst_pkt_len",   {23'h0, bus.pkt_len_o},   32'h0);
    chk("rst_mem_data",  bus.mem_data_o,           32'h0);
    chk("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("rst_out_data",  {24'h0, bus.out_data_o},  32'h0);
    chk("rst_out_last",  {31'h0, bus.out_last_o},  32'h0);
    rst = 1'b0;
    wait_in_ready("idle_ready");

    // 4-byte packet and executor accesses
    pkt[0] = 8'h45; pkt[1] = 8'h00; pkt[2] = 8'h00; pkt[3] = 8'h54;
    load(4, 1'b1);
    chk("hold_pkt_len",   {23'h0, bus.pkt_len_o},   32'd4);
    chk("hold_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h1);
    chk("hold_in_ready",  {31'h0, bus.in_ready_o},  32'h0);
    mem_op(1'b0, 32'd0,          4'd4, 32'h0,        32'h45000054);
    mem_op(1'b1, 32'd1,          4'd2, 32'hFFFF1234, 32'h0);
    mem_op(1'b0, 32'd0,          4'd4, 32'h0,        32'h45123454);
    mem_op(1'b0, 32'd3,          4'd1, 32'h0,        32'h00000054);
    mem_op(1'b0, 32'd0,          4'd0, 32'h0,        32'h00000000);
    mem_op(1'b0, 32'd0,          4'd7, 32'h0,        32'h45123454);
    mem_op(1'b1, 32'd254,        4'd2, 32'h0000AABB, 32'h0);
    mem_op(1'b0, 32'd254,        4'd4, 32'h0,        32'hAABB0000);
    mem_op(1'b1, 32'd255,        4'd2, 32'h0000CCDD, 32'h0);
    mem_op(1'b0, 32'd254,        4'd4, 32'h0,        32'hAACC0000);
    mem_op(1'b0, 32'd256,        4'd1, 32'h0,        32'h00000000);
    mem_op(1'b1, 32'h80000000,   4'd1, 32'h00000077, 32'h0);
    mem_op(1'b0, 32'd0,          4'd1, 32'h0,        32'h00000045);
    mem_op(1'b0, 32'hFFFFFFFF,   4'd4, 32'h0,        32'h00000000);
    mem_op(1'b0, 32'd254,        4'd2, 32'h0,        32'h0000AACC);
    mem_idle();
    step();
    chk("ce0_hold", bus.mem_data_o, 32'h0000AACC);

    // dump with stalls
    out_q.push_back('{8'h45, 1'b0});
    out_q.push_back('{8'h12, 1'b0});
    out_q.push_back('{8'h34, 1'b0});
    out_q.push_back('{8'h54, 1'b1});
    bus.dump_start_i = 1'b1;
    step();
    bus.dump_start_i = 1'b0;
    chk("dump_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus.out_ready_i = pat[i][0];
      step();
    end
    bus.out_ready_i = 1'b1;
    wait_in_ready("dump_to_idle");
    chk("dump_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("dump_count", n_out, 4);

    mem_op(1'b0, 32'd0, 4'd1, 32'h0, 32'h00000000);
    mem_idle();

    // overflow: 300 bytes, only the first 256 kept
    for (int i = 0; i < 300; i++) pkt[i] = (i < 256) ? 8'(i * 7 + 3) : 8'h99;
    load(300, 1'b1);
    chk("ovf_pkt_len",   {23'h0, bus.pkt_len_o},   32'd256);
    chk("ovf_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h1);
    mem_op(1'b0, 32'd252, 4'd4, 32'h0, 32'hE7EEF5FC);
    mem_op(1'b0, 32'd0,   4'd2, 32'h0, 32'h0000030A);
    mem_idle();

    // reset from HOLD, then reset mid-load
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hold_mem_data", bus.mem_data_o, 32'h0);
    wait_in_ready("rst_hold_idle");
    pkt[0] = 8'h11; pkt[1] = 8'h22;
    load(2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midload_pkt_len",   {23'h0, bus.pkt_len_o},   32'h0);
    chk("midload_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h0);
    chk("midload_in_ready",  {31'h0, bus.in_ready_o},  32'h0);
    wait_in_ready("midload_idle");
    pkt[0] = 8'h3C;
    load(1, 1'b1);
    chk("one_pkt_ready", {31'h0, bus.pkt_ready_o}, 32'h1);
    chk("one_pkt_len",   {23'h0, bus.pkt_len_o},   32'd1);
    mem_op(1'b0, 32'd0, 4'd1, 32'h0, 32'h0000003C);
    mem_idle();

    out_q.push_back('{8'h3C, 1'b1});
    bus.out_ready_i  = 1'b1;
    bus.dump_start_i = 1'b1;
    step();
    bus.dump_start_i = 1'b0;
    wait_in_ready("dump1_idle");
    chk("dump1_count",     n_out, 5);
    chk("dump1_out_valid", {31'h0, bus.out_valid_o}, 32'h0);

    step();
    step();
    chk("rd_q_empty",  rd_q.size(),  0);
    chk("out_q_empty", out_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkt_buf_mem.md
Name: pkt_buf_mem

Overview:
- Byte-addressed packet buffer that answers the executor's memory-initiator port: ce/we/addr/width/data requests.
- Also provides a byte-stream load port, fed by the ingress parser side, and a byte-stream dump port to the egress side.
- Sequences one packet at a time through load, execute and dump phases.
- Data on the executor port is big-endian: the byte at addr is the most significant byte of the access.

Parameters:
DEPTH, 256, buffer size in bytes (power of two)
ADDR_W, 8, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_i  in  1  load byte valid
in_data_i  in  8  load byte
in_last_i  in  1  final byte of packet
in_ready_o  out  1  buffer accepts load bytes
pkt_ready_o  out  1  packet loaded; executor port live
pkt_len_o  out  ADDR_W+1  stored packet length in bytes
mem_ce_i  in  1  executor access enable
mem_we_i  in  1  1 = write, 0 = read
mem_addr_i  in  32  byte address
mem_width_i  in  4  access width in bytes
mem_data_i  in  32  write data, right-aligned
mem_data_o  out  32  read data, right-aligned, registered
dump_start_i  in  1  begin egress of stored packet
out_valid_o  out  1  egress byte valid
out_data_o  out  8  egress byte
out_last_o  out  1  final egress byte
out_ready_i  in  1  egress sink accepts byte

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset values: in_ready_o=0, pkt_ready_o=0, pkt_len_o=0, mem_data_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, state=IDLE.
- Reset does not clear buffer contents. Reset mid-load or mid-dump abandons the packet and returns to IDLE next cycle.

States:
- IDLE: in_ready_o=1, write pointer=0. An accepted byte (in_valid_i&in_ready_o) is stored at address 0 and the state moves to LOAD, or to HOLD if in_last_i is also set.
- LOAD: in_ready_o=1. Each accepted byte is stored at the write pointer and the pointer increments. On an accepted byte with in_last_i, pkt_len_o=bytes accepted and the state moves to HOLD.
- HOLD: in_ready_o=0, pkt_ready_o=1, executor port served. dump_start_i=1 moves the state to DUMP; pkt_ready_o drops in the same cycle as the transition.
- DUMP: streams bytes 0..pkt_len_o-1.
  - out_valid_o, out_data_o and out_last_o are registered.
  - The first byte appears 1 cycle after entry.
  - A byte is held stable while out_ready_i=0 and advances on out_valid_o&out_ready_i.
  - out_last_o is set with byte pkt_len_o-1. The cycle after that byte is accepted: out_valid_o=0, state=IDLE.
- Overflow: bytes past DEPTH are still accepted (in_ready_o stays 1) but discarded. pkt_len_o saturates at DEPTH.

Executor port:
- Active only in HOLD. In other states, writes are ignored and mem_data_o is set to 0 on any ce.
- Read (ce=1, we=0): mem_data_o is loaded at the clock edge. Data is valid the cycle after the request and holds until the next read.
- Read data layout: for width w (1..4), mem_data_o = {zero-fill, byte[addr], …, byte[addr+w-1]}, with byte[addr] in bits 8w-1:8w-8.
- Write (ce=1, we=1): the low 8w bits of mem_data_i are stored big-endian starting at addr, committed at the edge. A read of the same bytes in the next cycle returns the new data.
- width=0: no access; a read returns 0. width>4: treated as 4.
- Unaligned access is fully supported.
- Out-of-range bytes (address ≥ DEPTH, including upper addr bits nonzero): write lanes are dropped; read lanes return 0. No wrap-around.
- ce=0: no state change; mem_data_o holds its value.

Test Plan:
- Load bytes 45,00,00,54 (last on 54) → pkt_len_o=4, pkt_ready_o=1. Read addr 0 width 4 → mem_data_o=0x45000054 on the following cycle.
- In HOLD: write addr 1 width 2 data 0xFFFF1234, then read addr 0 width 4 next cycle → 0x45123454. Read addr 3 width 1 → 0x00000054.
- Unaligned/out-of-range: DEPTH=256, bytes 254=AA, 255=BB. Read addr 254 width 4 → 0xAABB0000. Write addr 255 width 2 data 0xCCDD → byte 255=CC, nothing else changes. Width=0 read → 0.
- Overflow: load 300 bytes → pkt_len_o=256, byte 255 holds the 256th input byte, in_ready_o=1 throughout load.
- Dump of 4-byte packet with out_ready_i pattern 1,0,0,1,1,1 → bytes 45,12,34,54 each emitted exactly once, stable while stalled, out_last_o only with 54, then IDLE with in_ready_o=1.
- Reset asserted mid-load after 2 bytes → next cycle IDLE, pkt_len_o=0, pkt_ready_o=0. A subsequent 1-byte packet with in_last_i on the first byte → HOLD, pkt_len_o=1.
